// File: rtl/ws2812b_rx_decoder.sv
// rtl/ws2812b_rx_decoder.sv - WS2812B single-wire NRZ receiver: pulse-width bit decode, 24-bit GRB words, latch gap detect
module ws2812b_rx_decoder #(
    parameter int unsigned T_MIN_HIGH = 4,
    parameter int unsigned T_THRESH   = 38,
    parameter int unsigned T_MAX_HIGH = 96,
    parameter int unsigned T_RESET    = 3200,
    parameter int unsigned CNT_W      = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] data_out,
    output logic        data_valid,
    input  logic        data_ack,
    output logic        overrun,
    output logic        latch,
    output logic [7:0]  frame_len,
    output logic        bit_error
);

    localparam logic ST_SYNC = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] MIN_H   = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] THR_H   = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] MAX_H   = CNT_W'(T_MAX_HIGH);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             din_s_q, din_s_d;
    logic             din_q_q, din_q_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic             state_q, state_d;
    logic [23:0]      shreg_q, shreg_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [23:0]      data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;
    logic             latch_q, latch_d;
    logic [7:0]       frame_len_q, frame_len_d;
    logic             bit_error_q, bit_error_d;

    logic fall;
    logic gap;
    logic word_done;

    always_comb begin
        sync1_d      = din;
        din_s_d      = sync1_q;
        din_q_d      = din_s_q;
        hi_cnt_d     = '0;
        lo_cnt_d     = '0;
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        wcnt_d       = wcnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        latch_d      = 1'b0;
        frame_len_d  = frame_len_q;
        bit_error_d  = 1'b0;

        fall      = din_q_q & ~din_s_q;
        // Equality (not >=) so a saturated low run cannot retrigger the latch.
        gap       = ~din_s_q && (lo_cnt_q == GAP_C);
        word_done = (bitcnt_q == 5'd24);

        if (din_s_q) begin
            hi_cnt_d = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
        end else begin
            lo_cnt_d = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + CNT_ONE;
        end

        if (word_done) begin
            bitcnt_d     = '0;
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
            wcnt_d       = (wcnt_q == 8'hff) ? wcnt_q : wcnt_q + 8'd1;
            if (data_valid_q && !data_ack) begin
                overrun_d = 1'b1;
            end
        end else if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            ST_SYNC: begin
                if (gap) begin
                    state_d  = ST_RUN;
                    bitcnt_d = '0;
                    wcnt_d   = '0;
                end
            end
            default: begin
                if (fall && (hi_cnt_q >= MIN_H)) begin
                    if (hi_cnt_q > MAX_H) begin
                        bit_error_d = 1'b1;
                        bitcnt_d    = '0;
                        state_d     = ST_SYNC;
                    end else begin
                        shreg_d  = {shreg_q[22:0], (hi_cnt_q >= THR_H)};
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
                if (gap) begin
                    latch_d     = 1'b1;
                    frame_len_d = wcnt_q;
                    wcnt_d      = '0;
                    if (bitcnt_q != 5'd0) begin
                        bit_error_d = 1'b1;
                        bitcnt_d    = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            din_s_q      <= 1'b0;
            din_q_q      <= 1'b0;
            hi_cnt_q     <= '0;
            lo_cnt_q     <= '0;
            state_q      <= ST_SYNC;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            wcnt_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            latch_q      <= 1'b0;
            frame_len_q  <= '0;
            bit_error_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            din_s_q      <= din_s_d;
            din_q_q      <= din_q_d;
            hi_cnt_q     <= hi_cnt_d;
            lo_cnt_q     <= lo_cnt_d;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            wcnt_q       <= wcnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            latch_q      <= latch_d;
            frame_len_q  <= frame_len_d;
            bit_error_q  <= bit_error_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign latch      = latch_q;
    assign frame_len  = frame_len_q;
    assign bit_error  = bit_error_q;

endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// tb/tb_ws2812b_rx_decoder.sv - directed self-checking bench for ws2812b_rx_decoder
module tb_ws2812b_rx_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        data_ack = 1'b0;
    logic [23:0] data_out;
    logic        data_valid;
    logic        overrun;
    logic        latch;
    logic [7:0]  frame_len;
    logic        bit_error;

    int checks = 0;
    int errors = 0;
    int latch_cnt = 0;
    int berr_cnt = 0;
    int l0;
    int b0;
    int k;

    ws2812b_rx_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .overrun    (overrun),
        .latch      (latch),
        .frame_len  (frame_len),
        .bit_error  (bit_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (latch)     latch_cnt <= latch_cnt + 1;
        if (bit_error) berr_cnt  <= berr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pulse(input int h, input int l);
        din = 1'b1;
        tick(h);
        din = 1'b0;
        tick(l);
    endtask

    task automatic send_word(input logic [23:0] w, input int h0, input int h1);
        for (int i = 23; i >= 0; i--) begin
            send_pulse(w[i] ? h1 : h0, 30);
        end
    endtask

    task automatic ack_word();
        data_ack = 1'b1;
        tick(1);
        data_ack = 1'b0;
    endtask

    task automatic snap();
        tick(1);
        l0 = latch_cnt;
        b0 = berr_cnt;
    endtask

    initial begin
        logic [23:0] w1;
        w1 = 24'hA53CF0;

        tick(5);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_data_valid", data_valid, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_latch", latch, 0);
        check_eq("rst_frame_len", frame_len, 0);
        check_eq("rst_bit_error", bit_error, 0);
        rst_n = 1'b1;

        // Words before the first gap are not decoded; the gap itself gives no latch.
        snap();
        send_word(24'h123456, 26, 51);
        check_eq("presync_valid", data_valid, 0);
        tick(3210);
        check_eq("sync_no_latch", latch_cnt - l0, 0);

        // First word after the gap, with valid latency measured from the last fall.
        for (int i = 23; i >= 1; i--) begin
            send_pulse(w1[i] ? 51 : 26, 30);
        end
        din = 1'b1;
        tick(w1[0] ? 51 : 26);
        din = 1'b0;
        k = 0;
        while (!data_valid && k < 20) begin
            tick(1);
            k++;
        end
        check_eq("valid_latency", k, 4);
        check_eq("word1_data", data_out, 24'hA53CF0);
        tick(30);
        ack_word();
        check_eq("ack_clears_valid", data_valid, 0);

        // Gap closing a one-word frame, then a three-word frame with threshold-edge widths.
        snap();
        tick(3210);
        check_eq("gap1_latch", latch_cnt - l0, 1);
        check_eq("gap1_frame_len", frame_len, 1);
        snap();
        send_word(24'h3C5A96, 26, 51);
        check_eq("f2_w1", data_out, 24'h3C5A96);
        ack_word();
        send_word(24'hF0F00F, 4, 96);
        check_eq("f2_w2_minmax", data_out, 24'hF0F00F);
        ack_word();
        send_word(24'h8001FF, 37, 38);
        check_eq("f2_w3_thresh", data_out, 24'h8001FF);
        check_eq("f2_w3_valid", data_valid, 1);
        ack_word();
        tick(3210);
        check_eq("gap2_latch", latch_cnt - l0, 1);
        check_eq("gap2_frame_len", frame_len, 3);
        check_eq("gap2_no_berr", berr_cnt - b0, 0);
        check_eq("gap2_no_overrun", overrun, 0);
        snap();
        tick(300);
        check_eq("gap_no_repeat", latch_cnt - l0, 0);

        // Empty frame: a sub-minimum glitch restarts the low run, next gap reports zero words.
        snap();
        send_pulse(2, 3210);
        check_eq("empty_latch", latch_cnt - l0, 1);
        check_eq("empty_frame_len", frame_len, 0);
        check_eq("empty_no_berr", berr_cnt - b0, 0);

        // Over-long pulse mid-word: error, then ignored until a fresh gap.
        snap();
        for (int i = 0; i < 10; i++) send_pulse(51, 30);
        send_pulse(120, 30);
        check_eq("long_berr", berr_cnt - b0, 1);
        send_word(24'h555555, 26, 51);
        check_eq("after_err_valid", data_valid, 0);
        snap();
        tick(3210);
        check_eq("resync_no_latch", latch_cnt - l0, 0);
        send_word(24'h0F0F0F, 26, 51);
        check_eq("resync_valid", data_valid, 1);
        check_eq("resync_data", data_out, 24'h0F0F0F);

        // Second word without ack overwrites and sets overrun.
        send_word(24'h00FF00, 26, 51);
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_data", data_out, 24'h00FF00);
        check_eq("ovr_valid", data_valid, 1);
        ack_word();
        check_eq("ovr_ack_valid", data_valid, 0);
        check_eq("ovr_ack_clear", overrun, 0);

        // Partial word + glitch + gap: latch with bit_error, no new word.
        snap();
        for (int i = 0; i < 12; i++) send_pulse(i[0] ? 51 : 26, 30);
        send_pulse(3, 3210);
        check_eq("partial_latch", latch_cnt - l0, 1);
        check_eq("partial_berr", berr_cnt - b0, 1);
        check_eq("partial_no_valid", data_valid, 0);
        check_eq("partial_frame_len", frame_len, 2);
        check_eq("partial_data_kept", data_out, 24'h00FF00);

        // Reset with a word pending returns everything to reset values.
        send_word(24'h111111, 26, 51);
        check_eq("pre_rst_valid", data_valid, 1);
        rst_n = 1'b0;
        tick(2);
        check_eq("mid_rst_valid", data_valid, 0);
        check_eq("mid_rst_data", data_out, 0);
        check_eq("mid_rst_frame_len", frame_len, 0);
        rst_n = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
